// File: rtl/arp_reply_scheduler.sv
// arp_reply_scheduler: queues validated ARP requests and launches replies to CLK_TX over a toggle req/ack handshake
module arp_reply_scheduler #(
  parameter int          AW      = 2,
  parameter logic [15:0] GAP_CYC = 16'd16,
  parameter logic [15:0] TMO_CYC = 16'hFFFF
) (
  input  logic          CLK_RX,
  input  logic          ARESET,
  input  logic          i_enable,
  input  logic          i_req_valid,
  input  logic [47:0]   i_req_mac,
  input  logic [31:0]   i_req_ipv4,
  output logic          o_tx_req_toggle,
  output logic [47:0]   o_tx_mac,
  output logic [31:0]   o_tx_ipv4,
  input  logic          i_tx_ack_toggle,
  output logic          o_busy,
  output logic [AW:0]   o_level,
  output logic [15:0]   o_drop_cnt,
  output logic          o_timeout
);
  localparam int DEPTH = 1 << AW;
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT_ACK, S_GAP} state_t;
  logic          r_req_valid;
  logic [79:0]   r_req_data;
  logic          r_ack_s1;
  logic          r_ack_s2;
  logic [79:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic [15:0]   r_drop_cnt;
  state_t        r_state;
  logic          r_tx_toggle;
  logic [47:0]   r_tx_mac;
  logic [31:0]   r_tx_ipv4;
  logic [15:0]   r_tmo_cnt;
  logic [15:0]   r_gap_cnt;
  logic          r_timeout;
  logic          w_pop;
  logic          w_full;
  logic          w_dup;
  logic          w_drop;
  logic          w_push;
  logic [AW-1:0] w_tail;
  logic          w_acked;
  logic          w_tmo_hit;
  assign w_tail    = r_wr_ptr - AW'(1);
  assign w_pop     = (r_state == S_IDLE) && i_enable && (r_level != '0);
  assign w_full    = r_level == (AW+1)'(DEPTH);
  assign w_dup     = (r_level != '0) && (r_req_data == r_mem[w_tail]);
  assign w_drop    = r_req_valid && ((w_full && !w_pop) || w_dup);
  assign w_push    = r_req_valid && !w_drop;
  assign w_acked   = r_ack_s2 == r_tx_toggle;
  assign w_tmo_hit = ({1'b0, r_tmo_cnt} + 17'd1) >= {1'b0, TMO_CYC};
  // Register the parser request so admission checks act on an aligned copy; ENABLE gates acceptance here
  always_ff @(posedge CLK_RX) begin
    if (ARESET) begin
      r_req_valid <= 1'b0;
      r_req_data  <= '0;
    end else begin
      r_req_valid <= i_req_valid & i_enable;
      r_req_data  <= {i_req_mac, i_req_ipv4};
    end
  end
  // Two-flop synchroniser for the ack toggle coming from CLK_TX
  always_ff @(posedge CLK_RX) begin
    if (ARESET) begin
      r_ack_s1 <= 1'b0;
      r_ack_s2 <= 1'b0;
    end else begin
      r_ack_s1 <= i_tx_ack_toggle;
      r_ack_s2 <= r_ack_s1;
    end
  end
  // FIFO storage; contents are only meaningful below LEVEL so no reset is needed
  always_ff @(posedge CLK_RX) begin
    if (w_push) r_mem[r_wr_ptr] <= r_req_data;
  end
  // Pointers, occupancy and saturating drop counter
  always_ff @(posedge CLK_RX) begin
    if (ARESET) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_wr_ptr   <= r_wr_ptr + AW'(w_push);
      r_rd_ptr   <= r_rd_ptr + AW'(w_pop);
      r_level    <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_drop_cnt <= r_drop_cnt + 16'(w_drop && (r_drop_cnt != 16'hFFFF));
    end
  end
  // Reply FSM: load head, toggle a cycle later, wait for ack (never abandoned), then hold off for the gap
  always_ff @(posedge CLK_RX) begin
    if (ARESET) begin
      r_state     <= S_IDLE;
      r_tx_toggle <= 1'b0;
      r_tx_mac    <= '0;
      r_tx_ipv4   <= '0;
      r_tmo_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            {r_tx_mac, r_tx_ipv4} <= r_mem[r_rd_ptr];
            r_state               <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_tx_toggle <= ~r_tx_toggle;
          r_tmo_cnt   <= '0;
          r_state     <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (w_acked) begin
            r_gap_cnt <= GAP_CYC;
            r_state   <= S_GAP;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 16'(r_tmo_cnt != 16'hFFFF);
            r_timeout <= r_timeout | w_tmo_hit;
          end
        end
        S_GAP: begin
          r_gap_cnt <= (r_gap_cnt == '0) ? r_gap_cnt : r_gap_cnt - 16'd1;
          r_state   <= (r_gap_cnt == '0) ? S_IDLE : S_GAP;
        end
      endcase
    end
  end
  assign o_tx_req_toggle = r_tx_toggle;
  assign o_tx_mac        = r_tx_mac;
  assign o_tx_ipv4       = r_tx_ipv4;
  assign o_busy          = (r_state != S_IDLE) || (r_level != '0);
  assign o_level         = r_level;
  assign o_drop_cnt      = r_drop_cnt;
  assign o_timeout       = r_timeout;
endmodule
